// File: rtl/instr_mem_sync_if.sv
// Fetch, decode-handoff and program-load signals between the PC/control side and instr_mem_sync.
// The master is the datapath/loader side; the slave is the instruction memory.
interface instr_mem_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] pc;
  logic                  fetch_req;
  logic                  fetch_ready;
  logic                  flush;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  addr_err;
  logic                  prog_en;
  logic                  prog_we;
  logic [ADDR_WIDTH-1:0] prog_addr;
  logic [DATA_WIDTH-1:0] prog_data;
  logic                  prog_active;

  modport master (
    output pc, fetch_req, flush, instr_ready, prog_en, prog_we, prog_addr, prog_data,
    input  fetch_ready, instruction, instr_valid, addr_err, prog_active
  );

  modport slave (
    input  pc, fetch_req, flush, instr_ready, prog_en, prog_we, prog_addr, prog_data,
    output fetch_ready, instruction, instr_valid, addr_err, prog_active
  );
endinterface

// File: rtl/instr_mem_sync.sv
// Clocked instruction memory: registered fetch port with valid/ready and flush,
// plus a program-load port that is only live while the RUN/PROG mode FSM sits in PROG.
//
// state | meaning
// RUN   | fetches accepted, program writes dropped
// PROG  | program writes honoured, no new fetches (held word may still drain)
module instr_mem_sync #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  DEPTH      = 256,
  parameter bit                  BYTE_ADDR  = 1'b0,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0
) (
  input logic            clk,
  input logic            reset,
  instr_mem_sync_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    PROG = 1'b1
  } mode_t;

  mode_t mode;

  // Zero at power-up only; reset deliberately leaves the program intact.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_WIDTH-1:0] instr_q;
  logic                  valid_q;
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  bad_addr;
  logic                  ready;
  logic                  accept;
  logic                  wr_in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode <= RUN;
    end else if (mode == RUN && bus.prog_en) begin
      mode <= PROG;
    end else if (mode == PROG && !bus.prog_en) begin
      mode <= RUN;
    end
  end

  assign bus.prog_active = (mode == PROG);

  assign idx          = BYTE_ADDR ? (bus.pc >> 2) : bus.pc;
  assign misaligned   = BYTE_ADDR && (bus.pc[1:0] != 2'b00);
  assign out_of_range = ({1'b0, idx} >= DEPTH_LIM);
  assign bad_addr     = misaligned || out_of_range;

  // Flush wins over everything, so it also blocks acceptance in its own cycle.
  assign ready  = (mode == RUN) && !bus.flush && (!valid_q || bus.instr_ready);
  assign accept = bus.fetch_req && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      if (bad_addr) begin
        instr_q <= NOP_WORD;
        err_q   <= 1'b1;
      end else begin
        instr_q <= mem[idx[IDX_W-1:0]];
        err_q   <= 1'b0;
      end
    end else if (bus.instr_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.fetch_ready = ready;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.addr_err    = err_q;

  assign wr_in_range = ({1'b0, bus.prog_addr} < DEPTH_LIM);

  always_ff @(posedge clk) begin
    if (!reset && mode == PROG && bus.prog_we && wr_in_range) begin
      mem[bus.prog_addr[IDX_W-1:0]] <= bus.prog_data;
    end
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Drives a word-addressed and a byte-addressed instance with identical stimulus
// and compares both against a cycle-level reference model of the memory.
module tb_instr_mem_sync;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] NOP_W  = 32'h0000_0020;
  localparam logic [31:0] NOP_B  = 32'hFFFF_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc;
  logic        fetch_req;
  logic        flush;
  logic        instr_ready;
  logic        prog_en;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic        m_prog;
  logic        m_valid;
  logic [31:0] m_instr [2];
  logic        m_err   [2];
  logic [31:0] m_mem   [DEPTH];

  always #5 clk = ~clk;

  instr_mem_sync_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_w ();
  instr_mem_sync_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_b ();

  assign bus_w.pc = pc;           assign bus_b.pc = pc;
  assign bus_w.fetch_req = fetch_req;   assign bus_b.fetch_req = fetch_req;
  assign bus_w.flush = flush;     assign bus_b.flush = flush;
  assign bus_w.instr_ready = instr_ready; assign bus_b.instr_ready = instr_ready;
  assign bus_w.prog_en = prog_en; assign bus_b.prog_en = prog_en;
  assign bus_w.prog_we = prog_we; assign bus_b.prog_we = prog_we;
  assign bus_w.prog_addr = prog_addr; assign bus_b.prog_addr = prog_addr;
  assign bus_w.prog_data = prog_data; assign bus_b.prog_data = prog_data;

  instr_mem_sync #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(DEPTH), .BYTE_ADDR(1'b0), .NOP_WORD(NOP_W)
  ) dut_w (
    .clk(clk), .reset(rst), .bus(bus_w)
  );

  instr_mem_sync #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(DEPTH), .BYTE_ADDR(1'b1), .NOP_WORD(NOP_B)
  ) dut_b (
    .clk(clk), .reset(rst), .bus(bus_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("valid_w", {31'b0, bus_w.instr_valid}, {31'b0, m_valid});
    check_eq("valid_b", {31'b0, bus_b.instr_valid}, {31'b0, m_valid});
    check_eq("instr_w", bus_w.instruction, m_instr[0]);
    check_eq("instr_b", bus_b.instruction, m_instr[1]);
    check_eq("err_w", {31'b0, bus_w.addr_err}, {31'b0, m_err[0]});
    check_eq("err_b", {31'b0, bus_b.addr_err}, {31'b0, m_err[1]});
    check_eq("prog_active_w", {31'b0, bus_w.prog_active}, {31'b0, m_prog});
    check_eq("prog_active_b", {31'b0, bus_b.prog_active}, {31'b0, m_prog});
  endtask

  // Inputs are set before the call; checks ready, clocks once, updates the model, checks outputs.
  task automatic step();
    logic exp_rdy;
    int   idx;
    logic bad;
    #1;
    exp_rdy = !m_prog && !flush && (!m_valid || instr_ready);
    check_eq("fetch_ready_w", {31'b0, bus_w.fetch_ready}, {31'b0, exp_rdy});
    check_eq("fetch_ready_b", {31'b0, bus_b.fetch_ready}, {31'b0, exp_rdy});
    @(posedge clk);
    if (rst) begin
      m_prog  = 1'b0;
      m_valid = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_instr[d] = '0;
        m_err[d]   = 1'b0;
      end
    end else begin
      if (flush) begin
        m_valid = 1'b0;
        m_err[0] = 1'b0;
        m_err[1] = 1'b0;
      end else if (fetch_req && exp_rdy) begin
        m_valid = 1'b1;
        for (int d = 0; d < 2; d++) begin
          idx = (d == 1) ? int'(pc) / 4 : int'(pc);
          bad = (idx >= DEPTH) || (d == 1 && (int'(pc) % 4) != 0);
          m_err[d] = bad;
          if (bad) m_instr[d] = (d == 1) ? NOP_B : NOP_W;
          else     m_instr[d] = m_mem[idx];
        end
      end else if (instr_ready) begin
        m_valid = 1'b0;
      end
      if (m_prog && prog_we && int'(prog_addr) < DEPTH) m_mem[prog_addr] = prog_data;
      m_prog = prog_en;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle();
    rst = 1'b0; fetch_req = 1'b0; flush = 1'b0; instr_ready = 1'b0;
    prog_en = 1'b0; prog_we = 1'b0; pc = '0; prog_addr = '0; prog_data = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_prog = 1'b0; m_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin m_instr[d] = '0; m_err[d] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // program two words
    prog_en = 1'b1; step();
    prog_we = 1'b1; prog_addr = 8'd0; prog_data = 32'h02328020; step();
    prog_addr = 8'd1; prog_data = 32'h22340003; step();
    prog_we = 1'b0; prog_en = 1'b0; step();

    // back-to-back fetch
    fetch_req = 1'b1; instr_ready = 1'b1; pc = 8'd0; step();
    check_eq("plan_load0", bus_w.instruction, 32'h02328020);
    pc = 8'd1; step();
    check_eq("plan_load1", bus_w.instruction, 32'h22340003);
    fetch_req = 1'b0; step();

    // backpressure
    fetch_req = 1'b1; instr_ready = 1'b0; pc = 8'd0; step();
    pc = 8'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("plan_hold", bus_w.instruction, 32'h02328020);
    end
    instr_ready = 1'b1; step();
    check_eq("plan_release", bus_w.instruction, 32'h22340003);

    // flush with a pending request
    instr_ready = 1'b0; pc = 8'd0; flush = 1'b1; step();
    check_eq("plan_flush_valid", {31'b0, bus_w.instr_valid}, 32'd0);
    check_eq("plan_flush_instr", bus_w.instruction, 32'h22340003);
    flush = 1'b0;

    // range and alignment
    instr_ready = 1'b1; pc = 8'd20; step();
    check_eq("plan_range_err", {31'b0, bus_w.addr_err}, 32'd1);
    check_eq("plan_range_nop", bus_w.instruction, NOP_W);
    pc = 8'h06; step();
    check_eq("plan_misalign", {31'b0, bus_b.addr_err}, 32'd1);
    pc = 8'h04; step();
    check_eq("plan_byte_word1", bus_b.instruction, 32'h22340003);

    // write attempted in RUN is dropped
    fetch_req = 1'b0; prog_we = 1'b1; prog_addr = 8'd2; prog_data = 32'hFFFFFFFF; step();
    prog_we = 1'b0; fetch_req = 1'b1; pc = 8'd2; step();
    check_eq("plan_run_write", bus_w.instruction, 32'h0);

    // no fetch in PROG
    fetch_req = 1'b0; prog_en = 1'b1; step();
    fetch_req = 1'b1; step();
    check_eq("plan_prog_ready", {31'b0, bus_w.fetch_ready}, 32'd0);
    prog_en = 1'b0; step();

    // reset while holding
    instr_ready = 1'b0; pc = 8'd1; step();
    fetch_req = 1'b0; step();
    rst = 1'b1; step();
    check_eq("plan_rst_valid", {31'b0, bus_w.instr_valid}, 32'd0);
    check_eq("plan_rst_instr", bus_w.instruction, 32'd0);
    rst = 1'b0; fetch_req = 1'b1; instr_ready = 1'b1; step();
    check_eq("plan_rst_retain", bus_w.instruction, 32'h22340003);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) prog_en = ~prog_en;
      prog_we     = $urandom_range(0, 1) == 1;
      prog_addr   = 8'($urandom_range(0, 19));
      prog_data   = $urandom;
      pc          = 8'($urandom_range(0, 69));
      fetch_req   = $urandom_range(0, 3) != 0;
      flush       = $urandom_range(0, 9) == 0;
      instr_ready = $urandom_range(0, 2) != 0;
      step();
    end

    idle();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
